// File: rtl/booth_multiplier_if.sv
// Bundle of start/operand/result signals shared between the multiplier and its requester.
// START/busy/done handshake: a 0->1 transition of START sampled at clk launches a job using the
// M1/M2 values present at that edge; busy is high while the job runs; done pulses for one cycle
// when out has just been updated, and out holds until the next completed job.
interface booth_multiplier_if;
    logic        START;
    logic [7:0]  M1;
    logic [7:0]  M2;
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    modport master (
        output START, M1, M2,
        input  out, busy, done, dbg_state
    );

    modport slave (
        input  START, M1, M2,
        output out, busy, done, dbg_state
    );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential 8x8 signed radix-2 Booth multiplier, one step per clock, 9-clock latency.
// Define BOOTH_RESTART_EN to let a START rising edge abort and reload a running operation.
module booth_multiplier (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_multiplier_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [8:0]  a;
    logic [8:0]  m;
    logic [7:0]  q;
    logic        qm1;
    logic [3:0]  cnt;
    logic        start_q;
    logic [15:0] out_r;
    logic        busy_r;
    logic        done_r;

    logic        start_rise;
    logic        load;
    logic [8:0]  sum;

    assign start_rise = bus.START & ~start_q;

`ifdef BOOTH_RESTART_EN
    assign load = start_rise;
`else
    assign load = start_rise && (state == IDLE);
`endif

    always_comb begin
        sum = a;
        case ({q[0], qm1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            m       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            start_q <= 1'b0;
            out_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            start_q <= bus.START;
            done_r  <= 1'b0;
            if (load) begin
                a      <= '0;
                m      <= {bus.M1[7], bus.M1};
                q      <= bus.M2;
                qm1    <= 1'b0;
                cnt    <= 4'd8;
                busy_r <= 1'b1;
                state  <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        // Arithmetic shift of {sum, q, qm1} with the accumulator sign replicated.
                        a   <= {sum[8], sum[8:1]};
                        q   <= {sum[0], q[7:1]};
                        qm1 <= q[0];
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        out_r  <= {a[7:0], q};
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and swept checks of booth_multiplier: products, latency, START edge rules, reset.
module tb_booth_multiplier;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    booth_multiplier_if bus ();

    booth_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges after the load edge until done is seen; bounded so a stuck DUT cannot hang.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.done && cyc < 30);
    endtask

    task automatic run_mul(input logic [7:0] m1, input logic [7:0] m2,
                           input logic [15:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        bus.M1    = m1;
        bus.M2    = m2;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd9);
        check({tag, "_out"}, 32'(bus.out), 32'(exp));
        check({tag, "_idle"}, 32'({bus.busy, bus.dbg_state}), 32'd0);
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [7:0]  r1;
        logic [7:0]  r2;
        int          p;
        logic [15:0] pexp;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.M1    = '0;
        bus.M2    = '0;

        #23;
        check("reset_out", 32'(bus.out), 32'd0);
        check("reset_flags", 32'({bus.busy, bus.done}), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // -10 x 13 with START held high afterwards: exactly one done pulse.
        @(negedge clk);
        bus.M1    = 8'hF6;
        bus.M2    = 8'h0D;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        check("neg_busy", 32'(bus.busy), 32'd1);
        wait_done(cyc);
        check("neg_latency", 32'(cyc), 32'd9);
        check("neg_out", 32'(bus.out), 32'hFF7E);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("held_start_no_retrigger", 32'(pulses), 32'd0);
        check("held_start_idle", 32'(bus.busy), 32'd0);
        check("held_out_stable", 32'(bus.out), 32'hFF7E);
        @(negedge clk);
        bus.START = 1'b0;

        run_mul(8'h80, 8'h80, 16'h4000, "min_min");
        run_mul(8'h80, 8'h7F, 16'hC080, "min_max");
        run_mul(8'h7F, 8'h7F, 16'h3F01, "max_max");
        run_mul(8'h00, 8'hFF, 16'h0000, "zero");
        run_mul(8'hFF, 8'hFF, 16'h0001, "neg1_neg1");

        // Operand change at N+3, START re-pulse sampled at N+5.
        @(negedge clk);
        bus.M1    = 8'd3;
        bus.M2    = 8'd5;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2) begin
                bus.M1 = 8'd7;
                bus.M2 = 8'hFE;
            end
            if (cyc == 3) bus.START = 1'b0;
            if (cyc == 4) begin
                bus.START = 1'b1;
                bus.M1    = 8'hFD;
                bus.M2    = 8'd4;
            end
            if (cyc > 2 && cyc < 9) check("midrun_busy", 32'(bus.busy), 32'd1);
        end while (!bus.done && cyc < 30);
`ifdef BOOTH_RESTART_EN
        check("restart_latency", 32'(cyc), 32'd14);
        check("restart_out", 32'(bus.out), 32'hFFF4);
`else
        check("ignore_latency", 32'(cyc), 32'd9);
        check("ignore_out", 32'(bus.out), 32'h000F);
`endif
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-run, release with START already high: counts as a fresh rising edge.
        bus.M1    = 8'h40;
        bus.M2    = 8'h03;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        @(negedge clk);
        bus.M1 = 8'h12;
        bus.M2 = 8'h05;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus.busy), 32'd1);
        wait_done(cyc);
        check("post_rst_latency", 32'(cyc), 32'd9);
        check("post_rst_out", 32'(bus.out), 32'h005A);
        @(negedge clk);
        bus.START = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            r1   = 8'($urandom_range(0, 255));
            r2   = 8'($urandom_range(0, 255));
            p    = int'($signed(r1)) * int'($signed(r2));
            pexp = p[15:0];
            run_mul(r1, r2, pexp, "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential 8×8 signed multiplier using radix-2 Booth recoding. It sits in the multi-register datapath as a shared arithmetic unit. It takes two two's-complement operands on a START request and produces a 16-bit signed product after a fixed number of clock cycles. One Booth step is performed per clock, so the design area stays small compared with an array multiplier.

## Interface
- No parameters; operand width fixed at 8, product width 16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `START`  in  1  start request; a rising edge (0→1, sampled at `clk`) launches a multiplication.
- `M1`  in  8  multiplicand, signed two's complement.
- `M2`  in  8  multiplier, signed two's complement.
- `out`  out  16  signed product M1×M2; registered; holds last result.
- `busy`  out  1  high while a multiplication is in progress.
- `done`  out  1  one-cycle pulse when `out` has just been updated.

## Operation
- Internal registers:
  - `A` (9-bit accumulator, sign-extended).
  - `Q` (8-bit, multiplier).
  - `Qm1` (1-bit).
  - `M` (9-bit sign-extended M1).
  - `cnt` (4-bit).
  - `start_q` (previous START sample).
- Start detect: `start_rise = START & ~start_q`; `start_q` updates every edge.
- FSM states:
  - IDLE → RUN on `start_rise`. Loads A=0, Q=M2, Qm1=0, M=sext(M1), cnt=8.
  - RUN: each cycle inspects {Q[0],Qm1}:
    - 01 → A=A+M.
    - 10 → A=A−M.
    - 00/11 → no change.
    - Then arithmetic right shift of {A,Q,Qm1} by one, with A[8] replicated, and cnt=cnt−1.
    - When cnt reaches 0 after the 8th step → DONE.
  - DONE: `out`={A[7:0],Q}, `done`=1, → IDLE.
- The 9-bit accumulator guarantees no overflow for M1=−128. The full range −128×−128=+16384 is representable.
- Operand changes on M1/M2 after the load edge are ignored until the next start.
- START held high continuously does not retrigger; a new start needs START to go low then high.
- `out` changes only in DONE; it holds its value in IDLE and RUN.
- `start_rise` while busy is ignored (see Configuration).
- Reset (any time, including mid-RUN): state=IDLE, `out`=0, `busy`=0, `done`=0, all internal registers 0, `start_q`=0. A partial result is discarded.

## Timing
- Load edge = N (start_rise sampled).
- Booth steps occur at edges N+1…N+8.
- `out` is valid and `done`=1 after edge N+9, so latency is 9 clocks from the sampling edge.
- `busy` is high from after edge N until after edge N+9.
- `done` is high exactly one cycle (N+9 to N+10).
- Earliest next start is sampled at edge N+10 (state IDLE), provided START has toggled.
- START already high when `rst_n` releases counts as a rising edge at the first clock (`start_q` resets to 0).

## Configuration
- Macro `BOOTH_RESTART_EN`.
- Defined: `start_rise` during RUN or DONE aborts the current operation and reloads from the current M1/M2, behaving as the IDLE load. `out` is not updated for the aborted operation.
- Undefined: `start_rise` during RUN or DONE is ignored and the current operation completes normally.

## Test plan
- M1=0xF6 (−10), M2=0x0D (13), START 0→1 and held high → after 9 clocks `out`=0xFF7E (−130), `done` pulses once, with no further `done` while START stays high.
- M1=0x80, M2=0x80 → `out`=0x4000. M1=0x80, M2=0x7F → `out`=0xC080. M1=0x7F, M2=0x7F → `out`=0x3F01.
- M1=0x00, M2=0xFF → `out`=0x0000. M1=0xFF, M2=0xFF → `out`=0x0001.
- Change M1/M2 at cycle N+3 during RUN → result still reflects operands at load. Pulse START again mid-RUN → ignored without the macro; restarts with new operands and completes 9 cycles later when `BOOTH_RESTART_EN` is defined.
- Assert `rst_n`=0 at cycle N+5 → `busy`, `done`, `out` go 0 immediately. After release plus a START edge, a normal product is produced.
- Random sweep of 1000 operand pairs against a signed reference model → exact match, with `done` exactly 9 clocks after each start edge.
